// File: rtl/bist_scheduler.sv
// bist_scheduler: round-robin sharing of the single BIST state machine among NUM_REQ
// requesters, with a RUN-time watchdog that aborts a hung sequence.
//
// Ports:
//   clock        system clock, rising edge
//   reset        asynchronous active-low reset
//   req          level request per requester, held until its done pulse
//   bist_end     completion level from the BIST state machine
//   bist_start   start level to the BIST state machine, high for the whole sequence
//   sm_clear     one-cycle active-high reset pulse to the BIST state machine (timeout only)
//   grant        one-hot owner of the current sequence, 0 when idle
//   done         one-cycle pulse to the owner at sequence end
//   timeout_err  one-cycle pulse alongside done when the sequence timed out
//   busy         high whenever the scheduler is not idle
//
// All outputs are registered: the next-state logic computes next output values, which are
// captured together with the state.
module bist_scheduler #(
  parameter int unsigned NUM_REQ        = 4,
  parameter int unsigned TIMEOUT_CYCLES = 128,
  parameter int unsigned GAP_CYCLES     = 2
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [NUM_REQ-1:0] req,
  input  logic               bist_end,
  output logic               bist_start,
  output logic               sm_clear,
  output logic [NUM_REQ-1:0] grant,
  output logic [NUM_REQ-1:0] done,
  output logic               timeout_err,
  output logic               busy
);

  localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int unsigned PtrW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  localparam logic [CntW-1:0]    CntMax      = '1;
  localparam logic [CntW-1:0]    TimeoutLast = CntW'(TIMEOUT_CYCLES - 1);
  localparam logic [PtrW-1:0]    PtrInit     = PtrW'(NUM_REQ - 1);
  localparam logic [NUM_REQ-1:0] OneHot0     = {{(NUM_REQ - 1){1'b0}}, 1'b1};

  if (NUM_REQ < 2) begin : g_bad_num_req
    $error("bist_scheduler: NUM_REQ must be at least 2");
  end
  if (GAP_CYCLES < 1) begin : g_bad_gap
    $error("bist_scheduler: GAP_CYCLES must be at least 1");
  end

  typedef enum logic [1:0] {StIdle, StRun, StGap} state_e;

  state_e              state_q, state_d;
  logic [PtrW-1:0]     rr_q, rr_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic [NUM_REQ-1:0]  grant_q, grant_d;
  logic [NUM_REQ-1:0]  done_q, done_d;
  logic                bist_start_q, bist_start_d;
  logic                sm_clear_q, sm_clear_d;
  logic                timeout_err_q, timeout_err_d;
  logic                busy_q, busy_d;

  // Round-robin pick: first requester set, searching upward from rr_q+1 with wrap, so the
  // most recent owner has the lowest priority.
  logic [PtrW-1:0] sel;
  logic            sel_valid;
  int unsigned     idx;
  logic [PtrW-1:0] idx_p;

  always_comb begin
    sel       = rr_q;
    sel_valid = 1'b0;
    idx       = 0;
    idx_p     = '0;
    for (int unsigned i = 1; i <= NUM_REQ; i++) begin
      idx   = (32'(rr_q) + i) % NUM_REQ;
      idx_p = PtrW'(idx);
      if (!sel_valid && req[idx_p]) begin
        sel_valid = 1'b1;
        sel       = idx_p;
      end
    end
  end

  logic [CntW-1:0] cnt_inc;
  assign cnt_inc = (cnt_q == CntMax) ? cnt_q : cnt_q + CntW'(1);

  always_comb begin
    state_d       = state_q;
    rr_d          = rr_q;
    cnt_d         = cnt_q;
    grant_d       = '0;
    done_d        = '0;
    bist_start_d  = 1'b0;
    sm_clear_d    = 1'b0;
    timeout_err_d = 1'b0;

    unique case (state_q)
      StIdle: begin
        cnt_d = '0;
        if (sel_valid) begin
          state_d      = StRun;
          rr_d         = sel;
          grant_d      = OneHot0 << sel;
          bist_start_d = 1'b1;
        end
      end

      StRun: begin
        cnt_d        = cnt_inc;
        grant_d      = grant_q;
        bist_start_d = 1'b1;
        // bist_end is checked first so a completion on the last allowed cycle is normal.
        if (bist_end) begin
          state_d      = StGap;
          cnt_d        = '0;
          grant_d      = '0;
          bist_start_d = 1'b0;
          done_d       = grant_q;
        end else if (cnt_q == TimeoutLast) begin
          state_d       = StGap;
          cnt_d         = '0;
          grant_d       = '0;
          bist_start_d  = 1'b0;
          done_d        = grant_q;
          timeout_err_d = 1'b1;
          sm_clear_d    = 1'b1;
        end
      end

      StGap: begin
        cnt_d = cnt_inc;
        // Hold off until the minimum gap has elapsed and the state machine has dropped bist_end.
        if ((32'(cnt_q) + 1) >= GAP_CYCLES && !bist_end) begin
          state_d = StIdle;
          cnt_d   = '0;
        end
      end

      default: begin
        state_d = StIdle;
        cnt_d   = '0;
      end
    endcase

    busy_d = (state_d != StIdle);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q       <= StIdle;
      rr_q          <= PtrInit;
      cnt_q         <= '0;
      grant_q       <= '0;
      done_q        <= '0;
      bist_start_q  <= 1'b0;
      sm_clear_q    <= 1'b0;
      timeout_err_q <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      rr_q          <= rr_d;
      cnt_q         <= cnt_d;
      grant_q       <= grant_d;
      done_q        <= done_d;
      bist_start_q  <= bist_start_d;
      sm_clear_q    <= sm_clear_d;
      timeout_err_q <= timeout_err_d;
      busy_q        <= busy_d;
    end
  end

  assign bist_start  = bist_start_q;
  assign sm_clear    = sm_clear_q;
  assign grant       = grant_q;
  assign done        = done_q;
  assign timeout_err = timeout_err_q;
  assign busy        = busy_q;

endmodule
